// File: rtl/prog_loader.sv
// Serial-to-program-bus bridge: synchronizes a 3-wire host link, checks framed
// images (header, length, payload, XOR checksum) and strobes payload bytes out.
module prog_loader #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  HEADER      = 8'hA5
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       ser_cs_n,
   input  logic       ser_clk,
   input  logic       ser_data,
   output logic       prog_enable,
   output logic [7:0] prog_data,
   output logic       ctrl_hold,
   output logic       load_done,
   output logic       load_error
);

   typedef enum logic [2:0] {HDR, LEN, PAY, SUM, DRAIN} state_t;

   logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync, r_cs_sync;
   logic                   r_clk_dly, r_dat_dly, r_rise;
   logic [2:0]             r_bit_cnt;
   logic [7:0]             r_shift, r_byte, r_csum;
   logic                   r_byte_rdy;
   logic [8:0]             r_remaining;
   state_t                 r_state, w_post;
   logic                   w_cs_hi;

   assign w_cs_hi = r_cs_sync[SYNC_STAGES-1];

   // Data is delayed alongside the edge detector so it lines up with r_rise.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_clk_sync <= '0;
         r_dat_sync <= '0;
         r_cs_sync  <= '1;
         r_clk_dly  <= 1'b0;
         r_dat_dly  <= 1'b0;
         r_rise     <= 1'b0;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ser_clk};
         r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ser_data};
         r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], ser_cs_n};
         r_clk_dly  <= r_clk_sync[SYNC_STAGES-1];
         r_dat_dly  <= r_dat_sync[SYNC_STAGES-1];
         r_rise     <= r_clk_sync[SYNC_STAGES-1] & ~r_clk_dly;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_byte     <= '0;
         r_byte_rdy <= 1'b0;
      end else begin
         r_byte_rdy <= 1'b0;
         if (w_cs_hi) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
         end else if (r_rise) begin
            r_shift   <= {r_shift[6:0], r_dat_dly};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
               r_byte     <= {r_shift[6:0], r_dat_dly};
               r_byte_rdy <= 1'b1;
            end
         end
      end
   end

   // State after consuming any ready byte; chip-select handling is applied on top.
   always_comb begin
      w_post = r_state;
      if (r_byte_rdy) begin
         case (r_state)
            HDR:     w_post = (r_byte == HEADER) ? LEN : DRAIN;
            LEN:     w_post = PAY;
            PAY:     if (r_remaining == 9'd1) w_post = SUM;
            SUM:     w_post = DRAIN;
            default: w_post = r_state;
         endcase
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_state     <= HDR;
         r_remaining <= '0;
         r_csum      <= '0;
         prog_enable <= 1'b0;
         prog_data   <= '0;
         ctrl_hold   <= 1'b1;
         load_done   <= 1'b0;
         load_error  <= 1'b0;
      end else begin
         prog_enable <= 1'b0;
         if (r_byte_rdy) begin
            case (r_state)
               HDR: begin
                  if (r_byte == HEADER) begin
                     load_done  <= 1'b0;
                     load_error <= 1'b0;
                     ctrl_hold  <= 1'b1;
                     r_csum     <= '0;
                  end else begin
                     load_error <= 1'b1;
                  end
               end
               LEN: r_remaining <= {r_byte == 8'h00, r_byte};
               PAY: begin
                  prog_data   <= r_byte;
                  prog_enable <= 1'b1;
                  r_csum      <= r_csum ^ r_byte;
                  r_remaining <= r_remaining - 9'd1;
               end
               SUM: begin
                  if (r_byte == r_csum) begin
                     load_done <= 1'b1;
                     ctrl_hold <= 1'b0;
                  end else begin
                     load_error <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
         if (w_cs_hi) begin
            r_state <= HDR;
            if (w_post == LEN || w_post == PAY || w_post == SUM)
               load_error <= 1'b1;
         end else begin
            r_state <= w_post;
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a frame-level model predicts strobed bytes
// and final status flags; a monitor pops expected bytes on every strobe.
module tb_prog_loader;

   localparam logic [7:0] HEADER = 8'hA5;

   logic       clock = 1'b0;
   logic       rst, ser_cs_n, ser_clk, ser_data;
   logic       prog_enable, ctrl_hold, load_done, load_error;
   logic [7:0] prog_data;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  fr[$];
   logic        m_done, m_err, m_hold;

   prog_loader #(.SYNC_STAGES(2), .HEADER(HEADER)) dut (
      .clock(clock), .rst(rst), .ser_cs_n(ser_cs_n), .ser_clk(ser_clk),
      .ser_data(ser_data), .prog_enable(prog_enable), .prog_data(prog_data),
      .ctrl_hold(ctrl_hold), .load_done(load_done), .load_error(load_error)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clock) begin
      if (!rst && prog_enable) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_strobe: got data %0h expected no strobe", prog_data);
         end else begin
            check("prog_data", {24'h0, prog_data}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   // Frame-level reference: what the whole image should produce once delivered.
   task automatic model();
      int n;
      logic [7:0] x;
      if (fr.size() == 0) return;
      if (fr[0] != HEADER) begin m_err = 1'b1; return; end
      m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1;
      if (fr.size() < 2) begin m_err = 1'b1; return; end
      n = (fr[1] == 8'h00) ? 256 : int'(fr[1]);
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
         if (2 + i >= fr.size()) begin m_err = 1'b1; return; end
         exp_q.push_back(fr[2+i]);
         x ^= fr[2+i];
      end
      if (fr.size() < n + 3) begin m_err = 1'b1; return; end
      if (fr[n+2] == x) begin m_done = 1'b1; m_hold = 1'b0; end
      else m_err = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         ser_data = b[i];
         #30 ser_clk = 1'b1;
         #30 ser_clk = 1'b0;
      end
   endtask

   task automatic check_flags(input string tag);
      check({tag, "_pending"},  exp_q.size(), 0);
      check({tag, "_done"},     {31'h0, load_done},  {31'h0, m_done});
      check({tag, "_error"},    {31'h0, load_error}, {31'h0, m_err});
      check({tag, "_hold"},     {31'h0, ctrl_hold},  {31'h0, m_hold});
   endtask

   task automatic run_frame(input string tag);
      model();
      ser_cs_n = 1'b0;
      #100;
      foreach (fr[i]) send_byte(fr[i]);
      #100 ser_cs_n = 1'b1;
      #300;
      check_flags(tag);
   endtask

   initial begin
      logic [7:0] x;
      int len;
      rst = 1'b1; ser_cs_n = 1'b1; ser_clk = 1'b0; ser_data = 1'b0;
      m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1;
      #23;
      check("rst_enable", {31'h0, prog_enable}, 0);
      check("rst_data",   {24'h0, prog_data},   0);
      check_flags("reset");
      rst = 1'b0;
      #50;

      fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h44, 8'h77};
      run_frame("good");
      fr = '{8'hA5, 8'h02, 8'h0F, 8'hF0, 8'h00};
      run_frame("badsum");
      fr = '{8'h5A, 8'h01, 8'h33, 8'h33};
      run_frame("badhdr");
      fr = '{8'hA5, 8'h04, 8'h12, 8'h34};
      run_frame("abort");
      fr = '{8'hA5, 8'h01, 8'h5C, 8'h5C};
      run_frame("after_abort");

      fr.delete();
      fr.push_back(8'hA5); fr.push_back(8'h00);
      for (int i = 0; i < 256; i++) fr.push_back(i[7:0]);
      fr.push_back(8'h00);
      run_frame("len0");

      for (int f = 0; f < 16; f++) begin
         fr.delete();
         len = $urandom_range(1, 6);
         fr.push_back(($urandom_range(0, 7) == 0) ? 8'h3C : HEADER);
         fr.push_back(len[7:0]);
         x = 8'h00;
         for (int i = 0; i < len; i++) begin
            fr.push_back(8'($urandom));
            x ^= fr[fr.size()-1];
         end
         if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
         fr.push_back(x);
         if ($urandom_range(0, 3) == 0) fr.push_back(8'($urandom));
         if ($urandom_range(0, 4) == 0) begin
            int k;
            k = $urandom_range(1, fr.size() - 1);
            for (int i = 0; i < k; i++) void'(fr.pop_back());
         end
         run_frame("rand");
      end

      exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
      ser_cs_n = 1'b0;
      #100;
      send_byte(8'hA5); send_byte(8'h04); send_byte(8'hAA); send_byte(8'hBB);
      #200;
      check("midrst_strobes", exp_q.size(), 0);
      #3 rst = 1'b1;
      #1;
      exp_q.delete();
      m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1;
      check("midrst_enable", {31'h0, prog_enable}, 0);
      check("midrst_data",   {24'h0, prog_data},   0);
      check_flags("midrst");
      ser_cs_n = 1'b1;
      #50 rst = 1'b0;
      #100;
      fr = '{8'hA5, 8'h02, 8'hC3, 8'h81, 8'h42};
      run_frame("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
